alu_input_ctrl: RTL
===================

# alu_input_ctrl

Sequencing controller that sits between the board's switches and push-buttons and the combinational `alu`. It loads operand A, operand B and the operation code from a shared switch bus under three debounced buttons, in a fixed order. It then captures the ALU result into a registered LED output and flags it valid. All ALU inputs are registered here, so the ALU sees stable operands regardless of switch activity.

## Interface
- `NB_DATA`, 4: operand and result width; matches the ALU `NB_DATA`.
- `NB_OP`, 6: operation code width; matches the ALU `NB_OP`.
- `NB_SW`, 8: switch bus width; must be ≥ max(`NB_DATA`, `NB_OP`).
- `DB_CYCLES`, 1000000: consecutive stable cycles required to accept a button level change; the bench overrides it to 4.

- `clk`  in  1  single clock for all state.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_sw`  in  NB_SW  switch bus, asynchronous to `clk`, sampled only on an accepted load.
- `i_btn_a`  in  1  load-A button, asynchronous, active-high.
- `i_btn_b`  in  1  load-B button, asynchronous, active-high.
- `i_btn_op`  in  1  load-operation button, asynchronous, active-high.
- `i_alu_result`  in  NB_DATA  ALU output, driven by `o_leds` of `alu`.
- `o_alu_a`  out  NB_DATA  registered operand A, drives the ALU `i_datoA`.
- `o_alu_b`  out  NB_DATA  registered operand B, drives the ALU `i_datoB`.
- `o_alu_op`  out  NB_OP  registered operation code, drives the ALU `i_operation`.
- `o_leds`  out  NB_DATA  registered result shown on the board LEDs.
- `o_valid`  out  1  high while `o_leds` holds the result of the current A/B/op set.
- `o_state`  out  3  current FSM state, for debug LEDs.

## Operation
- Button front-end, one identical copy per button:
  - 2-FF synchronizer.
  - Debouncer: a stable level flips only after the synchronized level has held the opposite value for `DB_CYCLES` consecutive cycles. The counter clears on any mismatch and is `$clog2(DB_CYCLES+1)` bits wide.
  - Rising-edge detector on the stable level, producing a 1-cycle pulse (`pa`, `pb`, `pop`).
- FSM states and encodings: IDLE=0, HAVE_A=1, HAVE_B=2, EXEC=3, SHOW=4. Codes 5–7 are illegal and return to IDLE.
- IDLE:
  - `pa` → `o_alu_a` ← `i_sw[NB_DATA-1:0]`, go to HAVE_A.
  - `pb` and `pop` are ignored.
- HAVE_A:
  - `pb` → `o_alu_b` ← `i_sw[NB_DATA-1:0]`, go to HAVE_B.
  - `pa` → reload A, stay in HAVE_A.
  - `pop` is ignored.
- HAVE_B:
  - `pop` → `o_alu_op` ← `i_sw[NB_OP-1:0]`, go to EXEC.
  - `pa` → reload A, go to HAVE_A.
  - `pb` → reload B, stay in HAVE_B.
- EXEC: lasts one cycle. `o_leds` ← `i_alu_result`, go to SHOW. All pulses in this cycle are ignored.
- SHOW:
  - `o_valid`=1.
  - `pa` → reload A, go to HAVE_A.
  - `pb` and `pop` are ignored.
- Simultaneous pulses: only the transition listed for the current state acts; in HAVE_B, `pop` beats `pa`, which beats `pb`. The remaining pulses are dropped, not queued.
- Op codes are passed through unvalidated. Result width and wrap-around are the ALU's; this block only registers the value.
- `o_leds` holds the last captured result until the next EXEC, including after a restart.

## Timing
- Reset (async assert, sync release) sets `o_alu_a`=0, `o_alu_b`=0, `o_alu_op`=0, `o_leds`=0, `o_valid`=0 and `o_state`=0. Synchronizers, debounce counters, stable levels and edge registers all clear.
- Button-to-pulse latency: let edge 0 be the first `clk` edge that samples the button high. The pulse is asserted in cycle `DB_CYCLES`+2 after edge 0, provided the button is held throughout.
- Pulse count:
  - A press held at least `DB_CYCLES`+2 cycles produces exactly one pulse, however long it is held.
  - A glitch shorter than `DB_CYCLES` cycles produces no pulse.
  - A release must itself be stable for `DB_CYCLES` cycles before a new press can pulse.
- Load latency: a pulse in cycle n updates its register and `o_state` at edge n+1.
- Result latency from `pop` in cycle n:
  - EXEC in cycle n+1.
  - `o_leds` updated and `o_valid`=1 from edge n+2.
- `o_valid` falls at the edge that leaves SHOW.
- Reset mid-operation, in any state: outputs take their reset values immediately and no pulse survives reset.

## Test plan
- ADD: `DB_CYCLES`=4, `i_sw`=0x05 with A pressed, 0x03 with B, 0x20 with op → `o_leds`=0x8 and `o_valid`=1 exactly 2 cycles after the op pulse; `o_state` sequence is 0,1,2,3,4.
- SUB wrap: A=0x2, B=0x5, op=0x22 → `o_leds`=0xD.
- NOR: A=0x3, B=0x4, op=0x27 → `o_leds`=0x8.
- Out of order: press B, then op, in IDLE → `o_state` stays 0 and `o_alu_b`/`o_alu_op` stay 0. A following A/B/op sequence (A=0x6, B=0x2, op=0x20) still gives `o_leds`=0x8.
- Debounce: `i_btn_a` high for 3 cycles → no pulse and state stays 0. Held for 50 cycles → exactly one pulse, at cycle 6 after the first sampling edge.
- Restart and reset: from SHOW with `o_leds`=0x8, press A with `i_sw`=0x9 → `o_valid` 0, state 1, `o_alu_a`=0x9, `o_leds` still 0x8. Then assert `i_rst` mid-HAVE_B → all outputs 0 and state 0 before the next `clk` edge.

Source files
------------

// File: rtl/alu_input_ctrl.sv
// Operand/opcode loader for the board ALU: debounces three load buttons, latches
// A, B and op from the switch bus in order, then captures the ALU result to the LEDs.
module alu_input_ctrl #(
   parameter int unsigned NB_DATA   = 4,
   parameter int unsigned NB_OP     = 6,
   parameter int unsigned NB_SW     = 8,
   parameter int unsigned DB_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic [NB_SW-1:0]   i_sw,
   input  logic               i_btn_a,
   input  logic               i_btn_b,
   input  logic               i_btn_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_leds,
   output logic               o_valid,
   output logic [2:0]         o_state
);

   localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StHaveA = 3'd1,
      StHaveB = 3'd2,
      StExec  = 3'd3,
      StShow  = 3'd4
   } state_e;

   // Button front-end, bit 0 = A, bit 1 = B, bit 2 = op
   logic [2:0]      btn_raw;
   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      stable_q, stable_d;
   logic [2:0]      stable_dly_q;
   logic [CntW-1:0] cnt_q [3];
   logic [CntW-1:0] cnt_d [3];
   logic [2:0]      pulse;
   logic            pa, pb, pop;

   assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

   // Level flips only once the counter has already seen DB_CYCLES mismatching cycles
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign pulse = stable_q & ~stable_dly_q;
   assign pa    = pulse[0];
   assign pb    = pulse[1];
   assign pop   = pulse[2];

   // Load sequencer
   state_e             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d;
   logic [NB_DATA-1:0] b_q, b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] leds_q, leds_d;
   logic               valid_q, valid_d;
   logic [NB_DATA-1:0] sw_data;
   logic [NB_OP-1:0]   sw_op;
   logic               unused_sw;

   assign sw_data   = i_sw[NB_DATA-1:0];
   assign sw_op     = i_sw[NB_OP-1:0];
   assign unused_sw = ^i_sw;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      leds_d  = leds_q;
      case (state_q)
         StIdle: begin
            if (pa) begin
               a_d     = sw_data;
               state_d = StHaveA;
            end
         end
         StHaveA: begin
            if (pb) begin
               b_d     = sw_data;
               state_d = StHaveB;
            end else if (pa) begin
               a_d = sw_data;
            end
         end
         StHaveB: begin
            if (pop) begin
               op_d    = sw_op;
               state_d = StExec;
            end else if (pa) begin
               a_d     = sw_data;
               state_d = StHaveA;
            end else if (pb) begin
               b_d = sw_data;
            end
         end
         StExec: begin
            leds_d  = i_alu_result;
            state_d = StShow;
         end
         StShow: begin
            if (pa) begin
               a_d     = sw_data;
               state_d = StHaveA;
            end
         end
         default: state_d = StIdle;
      endcase
      valid_d = (state_d == StShow);
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         leds_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         leds_q  <= leds_d;
         valid_q <= valid_d;
      end
   end

   assign o_alu_a  = a_q;
   assign o_alu_b  = b_q;
   assign o_alu_op = op_q;
   assign o_leds   = leds_q;
   assign o_valid  = valid_q;
   assign o_state  = state_q;

endmodule
